// File: rtl/sram_c_banked.sv
// Multi-bank register-array SRAM with single-word reads, a contiguous burst-read
// engine with valid/last framing, a 1- or 2-cycle read latency and range-error reporting.
module sram_c_banked #(
    parameter int DATA_W    = 48,
    parameter int DEPTH     = 32,
    parameter int NUM_BANKS = 4,
    parameter int RD_LAT    = 1,
    parameter int AW        = $clog2(DEPTH),
    parameter int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int LW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BW-1:0]     wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [BW-1:0]     rd_bank,
    input  logic [AW-1:0]     rd_addr,
    input  logic              burst_start,
    input  logic [BW-1:0]     burst_bank,
    input  logic [AW-1:0]     burst_addr,
    input  logic [LW-1:0]     burst_len,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_vld,
    output logic              data_out_last,
    output logic              rd_err
);

    typedef enum logic {IDLE, BURST} state_e;

    // Zero-extended compares keep the range checks meaningful for non-power-of-two sizes.
    function automatic logic bank_ok(input logic [BW-1:0] b);
        return {{(32-BW){1'b0}}, b} < 32'(NUM_BANKS);
    endfunction

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} < 32'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

    state_e            state_q, state_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic              iss_vld, iss_last, iss_err;
    logic [BW-1:0]     iss_bank;
    logic [AW-1:0]     iss_addr;
    logic              wr_ok, wr_err_q;
    logic [DATA_W-1:0] rd_word;
    logic              s1_vld_q, s1_last_q, s1_err_q;
    logic [DATA_W-1:0] s1_data_q;

    assign wr_ok = wr_en && bank_ok(wr_bank) && addr_ok(wr_addr);
    assign busy  = (state_q == BURST);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        iss_vld  = 1'b0;
        iss_last = 1'b0;
        iss_err  = 1'b0;
        iss_bank = rd_bank;
        iss_addr = rd_addr;
        case (state_q)
            IDLE: begin
                if (burst_start) begin
                    if (burst_len != '0) begin
                        if (bank_ok(burst_bank) && addr_ok(burst_addr)) begin
                            state_d = BURST;
                            bank_d  = burst_bank;
                            addr_d  = burst_addr;
                            rem_d   = burst_len;
                        end else begin
                            iss_err = 1'b1;
                        end
                    end
                end else if (rd_en) begin
                    if (bank_ok(rd_bank) && addr_ok(rd_addr)) iss_vld = 1'b1;
                    else                                      iss_err = 1'b1;
                end
            end
            BURST: begin
                iss_vld  = 1'b1;
                iss_bank = bank_q;
                iss_addr = addr_q;
                iss_last = (rem_q == LW'(1));
                addr_d   = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                rem_d    = rem_q - LW'(1);
                if (iss_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-first bypass: a same-cycle write to the issued location wins over the array.
    assign rd_word = (wr_ok && wr_bank == iss_bank && wr_addr == iss_addr)
                     ? wr_data : mem_q[iss_bank][iss_addr];

    // NOTE: the array is deliberately reset, so it sits in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int a = 0; a < DEPTH; a++)
                    mem_q[b][a] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            wr_err_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_err_q  <= wr_en && !wr_ok;
            s1_vld_q  <= iss_vld;
            s1_last_q <= iss_last;
            s1_err_q  <= iss_err;
            if (iss_vld) s1_data_q <= rd_word;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign data_out      = s1_data_q;
        assign data_out_vld  = s1_vld_q;
        assign data_out_last = s1_last_q;
        assign rd_err        = s1_err_q | wr_err_q;
    end else begin : g_lat2
        logic              s2_vld_q, s2_last_q, s2_err_q;
        logic [DATA_W-1:0] s2_data_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s2_vld_q  <= 1'b0;
                s2_last_q <= 1'b0;
                s2_err_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q  <= s1_vld_q;
                s2_last_q <= s1_last_q;
                s2_err_q  <= s1_err_q;
                if (s1_vld_q) s2_data_q <= s1_data_q;
            end
        end

        // Write-range errors are reported the next cycle regardless of read latency.
        assign data_out      = s2_data_q;
        assign data_out_vld  = s2_vld_q;
        assign data_out_last = s2_last_q;
        assign rd_err        = s2_err_q | wr_err_q;
    end

endmodule

// File: doc/sram_c_banked.md
Name: sram_c_banked

Overview:
Parametrised successor to the single-bank column SRAM in the DFU. It holds NUM_BANKS independent register-array banks of DEPTH x DATA_W words. Single-word writes and reads are supported, plus a burst-read engine that streams a contiguous address run from one bank with valid/last framing. Read latency is configurable. Out-of-range accesses raise an error flag instead of being silently dropped.

Parameters:
DATA_W, 48, word width (three 16-bit elements)
DEPTH, 32, words per bank
NUM_BANKS, 4, number of banks
RD_LAT, 1, read latency in cycles (legal values 1 or 2)
AW, $clog2(DEPTH), address width (derived)
BW, max(1,$clog2(NUM_BANKS)), bank-select width (derived)
LW, AW+1, burst length width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
wr_en  in  1  write strobe
wr_bank  in  BW  write bank select
wr_addr  in  AW  write address
wr_data  in  DATA_W  write data
rd_en  in  1  single-word read strobe
rd_bank  in  BW  read bank select
rd_addr  in  AW  read address
burst_start  in  1  burst-read request
burst_bank  in  BW  burst bank
burst_addr  in  AW  burst start address
burst_len  in  LW  burst word count
busy  out  1  burst in progress
data_out  out  DATA_W  read data
data_out_vld  out  1  data_out valid
data_out_last  out  1  final word of a burst
rd_err  out  1  one-cycle error pulse

Behaviour:
- Reset (rst=0, async): every word of every bank = 0. data_out=0, data_out_vld=0, data_out_last=0, rd_err=0, busy=0, FSM=IDLE. Reset mid-burst aborts the burst with no further output.
- Write: if wr_en and wr_bank<NUM_BANKS and wr_addr<DEPTH, the word is written at the clock edge. An out-of-range write is ignored and pulses rd_err the next cycle.
- Collision: a write and a read to the same bank/address in the same cycle read as write-first. The read returns wr_data. Applies to single and burst reads.
- Read issue: the array is sampled in the issue cycle. Output appears RD_LAT cycles later. RD_LAT=1 means registered output the next cycle; RD_LAT=2 adds one pipeline stage. vld and last travel with the data.
- Single read: accepted only in IDLE. If in range, it produces one word with vld=1 and last=0. If out of range, vld=0 and rd_err pulses aligned to where vld would have appeared.
- rd_en while busy: ignored, no error.
- FSM IDLE:
  - burst_start with burst_bank/burst_addr in range and burst_len>0: latch bank, address and remaining=burst_len, then go to BURST. busy=1 from the next cycle.
  - Out-of-range start: rd_err pulse, stay IDLE.
  - burst_len=0: no-op, no output, no error.
  - burst_start has priority over rd_en in the same cycle. The rd_en is dropped.
- FSM BURST: issue one read per cycle. Address increments and wraps DEPTH-1 -> 0. remaining decrements. The word issued with remaining==1 carries last=1, and the FSM returns to IDLE with busy=0 on the following cycle. burst_start while busy is ignored.
- Back-to-back: a new burst_start may be accepted in the first IDLE cycle after busy falls. No gap is required in the output stream beyond that one cycle.
- When no read is issued, data_out holds its last value and vld=0.
- Writes are accepted in every state, including to the bank being burst-read.

Test Plan:
- Reset then write bank1 addr5=0xABCDEF012345, read bank1 addr5 (RD_LAT=1) -> data_out=0xABCDEF012345, vld=1 exactly one cycle after rd_en; read bank0 addr5 -> 0.
- Same cycle: wr bank2 addr3=0x111, rd bank2 addr3 -> returns 0x111 (write-first). Repeat with RD_LAT=2 -> same data, two cycles later.
- Fill bank0 addr i = i. burst addr30 len4 -> outputs 30,31,0,1 on consecutive cycles, last=1 only on 1. busy high for exactly 4 cycles.
- wr_addr=DEPTH (via AW overflow config DEPTH=24) and rd_addr=24 -> no array change, rd_err pulses, vld=0. burst_len=0 -> no output, no error.
- Assert rst low mid-burst at word 2 of 8 -> vld=0 and busy=0 immediately. Subsequent reads of all banks return 0.
- rd_en and a second burst_start during busy -> both ignored, stream unchanged. burst_start in the first idle cycle after busy falls -> accepted.
